// File: rtl/memory_arbiter.sv
// Serializes L1I and L1D traffic onto one backing-memory port, one word at a time.
// L1D has priority; a saturating streak counter forces an L1I grant after STARVE_LIMIT L1D wins.
`ifndef DATA_SOURCE_NONE
`define DATA_SOURCE_NONE 2'd0
`endif
`ifndef DATA_SOURCE_ROM
`define DATA_SOURCE_ROM 2'd1
`endif
`ifndef DATA_SOURCE_RAM
`define DATA_SOURCE_RAM 2'd2
`endif

module memory_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  l1i_req,
  input  logic [ADDR_WIDTH-1:0] l1i_address,
  input  logic                  l1d_req,
  input  logic                  l1d_write,
  input  logic [ADDR_WIDTH-1:0] l1d_address,
  input  logic [DATA_WIDTH-1:0] l1d_input_data,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic [1:0]            data_source,
  output logic                  stall_l1i,
  output logic                  stall_l1d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_LIMIT_C = 4'(STARVE_LIMIT);

  state_t                  state_r, state_s;
  logic                    mem_req_r, mem_req_s;
  logic                    mem_write_r, mem_write_s;
  logic [ADDR_WIDTH-1:0]   mem_address_r, mem_address_s;
  logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_s;
  logic [DATA_WIDTH-1:0]   output_data_r, output_data_s;
  logic [1:0]              data_source_r, data_source_s;
  logic                    winner_i_r, winner_i_s;
  logic [3:0]              streak_r, streak_s;
  logic                    grant_i_s;

  // Next-state, arbitration and transaction latching
  always_comb begin
    state_s       = state_r;
    mem_req_s     = mem_req_r;
    mem_write_s   = mem_write_r;
    mem_address_s = mem_address_r;
    mem_wdata_s   = mem_wdata_r;
    output_data_s = output_data_r;
    data_source_s = data_source_r;
    winner_i_s    = winner_i_r;
    streak_s      = streak_r;
    grant_i_s     = l1i_req & (~l1d_req | (streak_r >= STREAK_LIMIT_C));

    case (state_r)
      IDLE: begin
        if (l1i_req | l1d_req) begin
          state_s    = BUSY;
          mem_req_s  = 1'b1;
          winner_i_s = grant_i_s;
          if (grant_i_s) begin
            mem_address_s = l1i_address;
            mem_write_s   = 1'b0;
          end else begin
            mem_address_s = l1d_address;
            mem_write_s   = l1d_write;
            mem_wdata_s   = l1d_input_data;
          end
          // Streak only grows while L1I is actually being passed over
          if (!grant_i_s && l1i_req) begin
            streak_s = (streak_r == 4'hF) ? 4'hF : (streak_r + 4'd1);
          end else begin
            streak_s = 4'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_s   = RESP;
          mem_req_s = 1'b0;
          if (mem_write_r) begin
            data_source_s = `DATA_SOURCE_NONE;
          end else begin
            output_data_s = mem_rdata;
            data_source_s = winner_i_r ? `DATA_SOURCE_ROM : `DATA_SOURCE_RAM;
          end
        end else begin
          state_s = BUSY;
        end
      end
      RESP: begin
        state_s       = IDLE;
        data_source_s = `DATA_SOURCE_NONE;
      end
      default: begin
        state_s       = IDLE;
        mem_req_s     = 1'b0;
        data_source_s = `DATA_SOURCE_NONE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      mem_req_r     <= 1'b0;
      mem_write_r   <= 1'b0;
      mem_address_r <= '0;
      mem_wdata_r   <= '0;
      output_data_r <= '0;
      data_source_r <= `DATA_SOURCE_NONE;
      winner_i_r    <= 1'b0;
      streak_r      <= 4'd0;
    end else begin
      state_r       <= state_s;
      mem_req_r     <= mem_req_s;
      mem_write_r   <= mem_write_s;
      mem_address_r <= mem_address_s;
      mem_wdata_r   <= mem_wdata_s;
      output_data_r <= output_data_s;
      data_source_r <= data_source_s;
      winner_i_r    <= winner_i_s;
      streak_r      <= streak_s;
    end
  end

  assign mem_req     = mem_req_r;
  assign mem_write   = mem_write_r;
  assign mem_address = mem_address_r;
  assign mem_wdata   = mem_wdata_r;
  assign output_data = output_data_r;
  assign data_source = data_source_r;

  // Stalls drop only during the response cycle of the requester that was served
  assign stall_l1i = l1i_req & ~((state_r == RESP) &  winner_i_r);
  assign stall_l1d = l1d_req & ~((state_r == RESP) & ~winner_i_r);

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized bench for memory_arbiter, checked against a transaction-level
// reference model of the arbitration rules.
module tb_memory_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          l1i_req, l1d_req, l1d_write;
  logic [AW-1:0] l1i_address, l1d_address;
  logic [DW-1:0] l1d_input_data, mem_rdata;
  logic          mem_ready;
  logic          mem_req, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, output_data;
  logic [1:0]    data_source;
  logic          stall_l1i, stall_l1d;

  int checks = 0;
  int errors = 0;

  // Reference model: one outstanding transaction record plus a response flag
  bit          m_busy, m_resp, m_is_i, m_wr;
  logic [31:0] m_addr, m_wdata, m_out;
  int          m_streak;

  always #5 clock = ~clock;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset_n(reset_n),
    .l1i_req(l1i_req), .l1i_address(l1i_address),
    .l1d_req(l1d_req), .l1d_write(l1d_write), .l1d_address(l1d_address),
    .l1d_input_data(l1d_input_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .output_data(output_data), .data_source(data_source),
    .stall_l1i(stall_l1i), .stall_l1d(stall_l1d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_source();
    if (!m_resp || m_wr) return 2'd0;
    else return m_is_i ? 2'd1 : 2'd2;
  endfunction

  task automatic model_step();
    bit pick_i;
    if (!reset_n) begin
      m_busy = 1'b0; m_resp = 1'b0; m_is_i = 1'b0; m_wr = 1'b0;
      m_addr = 32'd0; m_wdata = 32'd0; m_out = 32'd0; m_streak = 0;
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy = 1'b0;
        m_resp = 1'b1;
        if (!m_wr) m_out = mem_rdata;
      end
    end else if (l1i_req || l1d_req) begin
      pick_i = l1i_req && (!l1d_req || m_streak >= LIM);
      m_streak = (!pick_i && l1i_req) ? ((m_streak >= 15) ? 15 : m_streak + 1) : 0;
      m_is_i = pick_i;
      m_addr = pick_i ? l1i_address : l1d_address;
      m_wr   = pick_i ? 1'b0 : l1d_write;
      if (!pick_i) m_wdata = l1d_input_data;
      m_busy = 1'b1;
    end
  endtask

  task automatic check_regs();
    chk("mem_req", 64'(mem_req), 64'(m_busy));
    chk("mem_write", 64'(mem_write), 64'(m_wr));
    chk("mem_address", 64'(mem_address), 64'(m_addr));
    if (m_busy && m_wr) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    chk("output_data", 64'(output_data), 64'(m_out));
    chk("data_source", 64'(data_source), 64'(exp_source()));
  endtask

  // Called just after inputs are driven: check stalls, advance model, cross the edge, check regs
  task automatic cycle();
    #1;
    chk("stall_l1i", 64'(stall_l1i), 64'(l1i_req && !(m_resp && m_is_i)));
    chk("stall_l1d", 64'(stall_l1d), 64'(l1d_req && !(m_resp && !m_is_i)));
    model_step();
    @(posedge clock);
    #1;
    check_regs();
  endtask

  initial begin
    string order;
    reset_n = 1'b0; l1i_req = 1'b0; l1d_req = 1'b0; l1d_write = 1'b0;
    l1i_address = '0; l1d_address = '0; l1d_input_data = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    m_busy = 1'b0; m_resp = 1'b0; m_is_i = 1'b0; m_wr = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; m_out = 32'd0; m_streak = 0;
    @(posedge clock); #1;
    cycle(); cycle();
    chk("reset_src", 64'(data_source), 64'd0);
    chk("reset_req", 64'(mem_req), 64'd0);
    reset_n = 1'b1;
    cycle();

    // Single L1I read, memory answers on the third BUSY cycle
    l1i_req = 1'b1; l1i_address = 32'h40;
    cycle();
    chk("t1_addr", 64'(mem_address), 64'h40);
    cycle(); cycle();
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    cycle();
    chk("t1_src", 64'(data_source), 64'd1);
    chk("t1_data", 64'(output_data), 64'hDEADBEEF);
    mem_ready = 1'b0; mem_rdata = 32'h0;
    cycle();
    l1i_req = 1'b0;
    cycle();

    // L1D write
    l1d_req = 1'b1; l1d_write = 1'b1; l1d_address = 32'h100; l1d_input_data = 32'h5A5A;
    cycle();
    chk("t2_wr", 64'(mem_write), 64'd1);
    chk("t2_wdata", 64'(mem_wdata), 64'h5A5A);
    mem_ready = 1'b1;
    cycle();
    chk("t2_src", 64'(data_source), 64'd0);
    chk("t2_data", 64'(output_data), 64'hDEADBEEF);
    mem_ready = 1'b0;
    cycle();
    l1d_req = 1'b0; l1d_write = 1'b0;
    cycle();

    // Contention: both held, memory always ready
    l1i_req = 1'b1; l1d_req = 1'b1; l1i_address = 32'h1000; l1d_address = 32'h2000;
    mem_ready = 1'b1; mem_rdata = 32'h77;
    order = "";
    for (int n = 0; n < 60 && order.len() < 10; n++) begin
      cycle();
      if (data_source == 2'd1) order = {order, "I"};
      else if (data_source == 2'd2) order = {order, "D"};
    end
    checks++;
    assert (order == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order observed=%s expected=DDDDIDDDDI", order);
    end
    l1i_req = 1'b0; l1d_req = 1'b0; mem_ready = 1'b0;
    cycle(); cycle();

    // Flush: L1I drops its request in the second BUSY cycle
    l1i_req = 1'b1; l1i_address = 32'h80;
    cycle();
    cycle();
    l1i_req = 1'b0;
    cycle();
    chk("t4_req", 64'(mem_req), 64'd1);
    mem_ready = 1'b1; mem_rdata = 32'h1234;
    cycle();
    chk("t4_src", 64'(data_source), 64'd1);
    mem_ready = 1'b0;
    cycle();

    // Reset abort during BUSY, stray mem_ready afterwards
    l1d_req = 1'b1; l1d_address = 32'h200;
    cycle(); cycle();
    reset_n = 1'b0; l1d_req = 1'b0;
    cycle();
    chk("t5_req", 64'(mem_req), 64'd0);
    reset_n = 1'b1;
    cycle();
    mem_ready = 1'b1; mem_rdata = 32'hBAD;
    cycle();
    chk("t5_src", 64'(data_source), 64'd0);
    mem_ready = 1'b0;
    cycle();
    chk("t5_src2", 64'(data_source), 64'd0);

    // mem_ready while IDLE with no requests
    mem_ready = 1'b1; mem_rdata = 32'hFFFF;
    cycle();
    chk("t6_data", 64'(output_data), 64'd0);
    chk("t6_req", 64'(mem_req), 64'd0);
    mem_ready = 1'b0;
    cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 4) == 0) l1i_req = ~l1i_req;
      if ($urandom_range(0, 4) == 0) l1d_req = ~l1d_req;
      l1d_write      = $urandom_range(0, 1) == 1;
      l1i_address    = $urandom();
      l1d_address    = $urandom();
      l1d_input_data = $urandom();
      mem_rdata      = $urandom();
      mem_ready      = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
Arbitrates L1I and L1D miss/write traffic onto a single shared backing-memory port. Lives between the two l1 instances and the backing memory, and replaces the combinational stall/data_source steering in memory_controller. Serializes one word-sized transaction at a time and gives L1D priority, with a starvation guard for L1I. Returns read data together with the data_source tag that the l1 blocks use for should_cache, plus per-requester stall signals.

Parameters:
ADDR_WIDTH, 32, address width of requesters and memory port
DATA_WIDTH, 32, data word width
STARVE_LIMIT, 4, consecutive L1D grants allowed while L1I waits before L1I is forced (range 1..15)

Ports:
clock  input  1  CPU clock (cpu_clock domain)
reset_n  input  1  synchronous reset, active-low
l1i_req  input  1  L1I read request, level, held until served
l1i_address  input  ADDR_WIDTH  L1I read address
l1d_req  input  1  L1D request, level, held until served
l1d_write  input  1  1 = write, 0 = read
l1d_address  input  ADDR_WIDTH  L1D address
l1d_input_data  input  DATA_WIDTH  L1D write data
mem_req  output  1  backing-memory request, held until mem_ready
mem_write  output  1  backing-memory write enable
mem_address  output  ADDR_WIDTH  latched transaction address
mem_wdata  output  DATA_WIDTH  latched write data
mem_rdata  input  DATA_WIDTH  backing-memory read data, valid with mem_ready
mem_ready  input  1  one-cycle completion pulse
output_data  output  DATA_WIDTH  registered read data to both l1 blocks
data_source  output  2  NONE=0, ROM=1 (L1I fill), RAM=2 (L1D fill); uses the `DATA_SOURCE_* defines
stall_l1i  output  1  L1I must hold request
stall_l1d  output  1  L1D must hold request

Behaviour:
- FSM states: IDLE, BUSY, RESP. Registered state; all outputs except stalls are registered.
- Reset (reset_n=0 at a clock edge): state=IDLE, mem_req=0, mem_write=0, mem_address=0, mem_wdata=0, output_data=0, data_source=NONE, streak=0.
- Reset during BUSY aborts the transaction. mem_req is 0 from the next cycle. A later mem_ready is ignored.
- IDLE, no requests: stay in IDLE.
- IDLE, requests present: pick a winner and go to BUSY next cycle.
  - Only one requester: that requester wins.
  - Both requesting: L1D wins, unless streak >= STARVE_LIMIT, in which case L1I wins.
  - Latch address, write flag (0 for L1I) and wdata into mem_*. Record the winner. Set mem_req=1.
- Streak counter (4 bits, saturating):
  - increments on an L1D grant while l1i_req=1;
  - clears on an L1I grant, or on any grant made while l1i_req=0.
- BUSY: hold mem_req and all mem_* stable until mem_ready=1. On mem_ready:
  - mem_req=0 next cycle;
  - for a read, output_data <= mem_rdata;
  - go to RESP.
- RESP (exactly one cycle):
  - data_source = ROM for an L1I read, RAM for an L1D read, NONE for an L1D write.
  - output_data holds the read word; it is unchanged on writes.
  - Next state is IDLE. Arbitration happens in IDLE, so back-to-back grants are separated by at least one IDLE cycle.
- data_source is NONE in IDLE and BUSY.
- Stalls are combinational:
  - stall_l1i = l1i_req && !(state==RESP && winner==L1I);
  - stall_l1d is defined the same way for L1D.
- Minimum latency: request visible in IDLE at cycle 0 -> mem_req at cycle 1 -> mem_ready at cycle 1 -> RESP (stall low) at cycle 2.
- A requester that drops req during BUSY (e.g. pipeline flush) does not cancel the transaction. RESP still occurs with its data_source, and the l1 may ignore it.
- mem_ready outside BUSY is ignored.
- Address and data inputs changing during BUSY have no effect (latched values are used).

Test Plan:
- Single L1I read: l1i_req=1, address 0x40, memory returns 0xDEADBEEF after 3 cycles.
  -> mem_req for 3 cycles with mem_address=0x40, then one RESP cycle: data_source=1, output_data=0xDEADBEEF, stall_l1i=0; IDLE afterwards.
- L1D write: l1d_req=1, l1d_write=1, address 0x100, data 0x5A5A.
  -> mem_write=1, mem_wdata=0x5A5A; RESP with data_source=0, output_data unchanged, stall_l1d low for one cycle.
- Contention with STARVE_LIMIT=4: both requesters held high continuously.
  -> grant order D,D,D,D,I,D,D,D,D,I; stall of the non-served requester stays 1 throughout.
- Flush mid-transaction: l1i_req drops in the 2nd BUSY cycle.
  -> mem_req stays high until mem_ready; RESP still shows data_source=1.
- Reset abort: reset_n=0 in BUSY, mem_ready pulses 2 cycles after reset release.
  -> mem_req=0 from the cycle after reset; stray mem_ready produces no RESP and data_source stays 0.
- mem_ready pulse while IDLE with no requests -> no state change, output_data unchanged.
